// File: rtl/uart_types_pkg.sv
// Shared UART register types, receiver FSM encoding and the parity helper
// used by both the receive and transmit paths.
package uart_types_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    // Line control register, 16550 bit layout (MSB first).
    typedef struct packed {
        logic       dlab;
        logic       set_break;
        logic       stick_parity;
        logic       eps;
        logic       pen;
        logic       stb;
        logic [1:0] wls;
    } lcr_t;

    typedef struct packed {
        logic [7:0] dmsb;
        logic [7:0] dlsb;
    } div_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    typedef struct packed {
        logic bi;
        logic fe;
        logic pe;
    } rx_status_t;

    // Parity bit for a 5..8-bit character; bits above the word length are ignored.
    function automatic logic uart_parity(input logic [7:0] data, input logic [1:0] wls,
                                         input logic eps, input logic stick);
        logic [7:0] mask;
        logic       red;
        mask = 8'hFF >> (3'd3 - {1'b0, wls});
        red  = ^(data & mask);
        if (stick) begin
            return ~eps;
        end
        return eps ? red : ~red;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate divisor: one-clock tick every `div` clocks, silent when div is 0.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt_q;

    assign tick = (div != 16'd0) && (cnt_q == div - 16'd1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of block ordering.
        if (rst || clear || tick || (div == 16'd0)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchroniser, 16x oversampling framer and a single-entry
// holding register that hands characters and line-status flags to the FIFO layer.
module uart_rx_core
    import uart_types_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  lcr_t       lcr,
    input  div_t       div,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       pe_o,
    output logic       fe_o,
    output logic       bi_o,
    output logic       oe_o,
    output logic       busy_o
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic                   line_q;

    rx_state_e state_q;
    rx_state_e state_d;

    div_t            div_q;
    logic [1:0]      wls_q;
    logic            pen_q;
    logic            eps_q;
    logic            stick_q;
    logic [OS_W-1:0] os_cnt;
    logic [2:0]      bit_idx;
    logic [2:0]      last_bit;
    logic [7:0]      shreg;
    logic            par_q;
    logic            pe_q;

    logic       tick;
    logic       sample;
    logic       start_det;
    logic       frame_done;
    logic [7:0] data_aligned;
    logic       exp_par;
    logic       fe_now;
    logic       bi_now;

    logic [7:0] data_q;
    rx_status_t status_q;
    logic       valid_q;
    logic       oe_q;

    // Framing ignores stop-bit count, DLAB and break generation.
    logic lcr_unused;
    assign lcr_unused = ^{lcr.stb, lcr.dlab, lcr.set_break};

    assign line = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            line_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            line_q <= line;
        end
    end

    uart_baud_gen u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(start_det),
        .div  ({div_q.dmsb, div_q.dlsb}),
        .tick (tick)
    );

    assign sample       = tick && (os_cnt == OS_MID);
    assign last_bit     = 3'd4 + {1'b0, wls_q};
    assign data_aligned = shreg >> (3'd3 - {1'b0, wls_q});
    assign exp_par      = uart_parity(data_aligned, wls_q, eps_q, stick_q);
    assign fe_now       = !line;
    assign bi_now       = (data_aligned == 8'd0) && (!par_q || !pen_q) && !line;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d    = state_q;
        start_det  = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (({div.dmsb, div.dlsb} != 16'd0) && line_q && !line) begin
                    start_det = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (sample) begin
                    state_d = line ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_idx == last_bit)) begin
                    state_d = pen_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    frame_done = 1'b1;
                    // A low stop bit may be a break; wait for the line to recover.
                    state_d    = line ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (line) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            wls_q   <= '0;
            pen_q   <= 1'b0;
            eps_q   <= 1'b0;
            stick_q <= 1'b0;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
        end else if (start_det) begin
            div_q   <= div;
            wls_q   <= lcr.wls;
            pen_q   <= lcr.pen;
            eps_q   <= lcr.eps;
            stick_q <= lcr.stick_parity;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            if (tick) begin
                os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
            end
            if (sample && (state_q == DATA)) begin
                shreg   <= {line, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (sample && (state_q == PARITY)) begin
                par_q <= line;
                pe_q  <= (line != exp_par);
            end
        end
    end

    // A completed frame loads only if the holding register is free this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            oe_q <= frame_done && valid_q && !rx_ready_i;
            if (frame_done && (!valid_q || rx_ready_i)) begin
                data_q   <= data_aligned;
                status_q <= '{bi: bi_now, fe: fe_now, pe: pe_q};
                valid_q  <= 1'b1;
            end else if (valid_q && rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_data_o  = data_q;
    assign rx_valid_o = valid_q;
    assign pe_o       = status_q.pe;
    assign fe_o       = status_q.fe;
    assign bi_o       = status_q.bi;
    assign oe_o       = oe_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framing formats, error flags, break,
// glitch rejection, overrun, handshake collision, reset mid-frame and div=0.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lcr;
    logic [15:0] div;
    logic        rx_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        pe_o;
    logic        fe_o;
    logic        bi_o;
    logic        oe_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    int   cyc       = 0;
    int   start_cyc = 0;
    int   rise_cyc  = 0;
    int   rise_cnt  = 0;
    int   oe_cnt    = 0;
    int   busy_cnt  = 0;
    logic valid_prev = 1'b0;
    int   bit_clks  = 16;

    int r0;
    int o0;
    int b0;

    uart_rx_core dut (
        .clk       (clk),
        .rst       (rst),
        .lcr       (lcr),
        .div       (div),
        .rx_i      (rx_i),
        .rx_data_o (rx_data_o),
        .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i),
        .pe_o      (pe_o),
        .fe_o      (fe_o),
        .bi_o      (bi_o),
        .oe_o      (oe_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid_o && !valid_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        valid_prev = rx_valid_o;
        if (oe_o) oe_cnt++;
        if (busy_o) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input bit with_par,
                              input logic par, input logic stop);
        @(negedge clk);
        start_cyc = cyc;
        rx_i = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx_i = data[i];
            repeat (bit_clks) @(negedge clk);
        end
        if (with_par) begin
            rx_i = par;
            repeat (bit_clks) @(negedge clk);
        end
        rx_i = stop;
        repeat (bit_clks) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!rx_valid_o && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({tag, " valid"}, rx_valid_o, 1);
    endtask

    task automatic accept_char(input string tag);
        @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        check({tag, " valid drop"}, rx_valid_o, 0);
    endtask

    task automatic expect_char(input string tag, input logic [7:0] data,
                               input logic pe, input logic fe, input logic bi);
        wait_valid(tag, 200);
        check({tag, " data"}, rx_data_o, data);
        check({tag, " pe"}, pe_o, pe);
        check({tag, " fe"}, fe_o, fe);
        check({tag, " bi"}, bi_o, bi);
        accept_char(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        rx_i       = 1'b1;
        rx_ready_i = 1'b0;
        lcr        = 8'h03;
        div        = 16'd1;
        bit_clks   = 16;
        repeat (3) @(negedge clk);
        check("reset data", rx_data_o, 0);
        check("reset flags", {rx_valid_o, pe_o, fe_o, bi_o, oe_o, busy_o}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1, div=1; valid 16*9+8 clocks after detection, plus 2 sync and 1 edge register.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("8N1 latency", rise_cyc - start_cyc, 155);
        expect_char("8N1 A5", 8'hA5, 1'b0, 1'b0, 1'b0);

        // 7E1, div=3: 0x41 has two ones, so even parity bit is 0.
        div      = 16'd3;
        bit_clks = 48;
        lcr      = 8'h1A;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
        expect_char("7E1 bad par", 8'h41, 1'b1, 1'b0, 1'b0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
        expect_char("7E1 good par", 8'h41, 1'b0, 1'b0, 1'b0);

        // 5N1 with low stop bit, then a 40-bit-time break.
        div      = 16'd1;
        bit_clks = 16;
        lcr      = 8'h00;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        expect_char("5N1 fe", 8'h1F, 1'b0, 1'b1, 1'b0);
        r0 = rise_cnt;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (40 * 16) @(negedge clk);
        check("break count", rise_cnt - r0, 1);
        check("break busy", busy_o, 1);
        expect_char("break", 8'h00, 1'b0, 1'b1, 1'b1);
        repeat (64) @(negedge clk);
        check("break no retrigger", rise_cnt - r0, 1);
        rx_i = 1'b1;
        repeat (32) @(negedge clk);
        check("break idle", busy_o, 0);

        // Glitch: 4 ticks low is rejected at the start-bit mid-sample.
        lcr = 8'h03;
        r0  = rise_cnt;
        @(negedge clk);
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        check("glitch busy", busy_o, 1);
        repeat (20) @(negedge clk);
        check("glitch idle", busy_o, 0);
        check("glitch no char", rise_cnt - r0, 0);

        // Overrun: two back-to-back frames with ready held low.
        o0 = oe_cnt;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("overrun pulses", oe_cnt - o0, 1);
        check("overrun data", rx_data_o, 8'h11);
        check("overrun valid", rx_valid_o, 1);

        // Accept of 0x11 lands in the same cycle that 0x33 completes.
        fork
            send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(negedge clk);
                rx_ready_i = 1'b1;
                @(negedge clk);
                rx_ready_i = 1'b0;
            end
        join
        repeat (2) @(negedge clk);
        check("collide data", rx_data_o, 8'h33);
        check("collide valid", rx_valid_o, 1);
        check("collide no oe", oe_cnt - o0, 1);
        accept_char("collide");

        // Reset in the middle of the data bits of 0x55.
        @(negedge clk);
        rx_i = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = (i % 2 == 0);
            repeat (16) @(negedge clk);
        end
        rst  = 1'b1;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        check("mid reset busy", busy_o, 0);
        check("mid reset valid", rx_valid_o, 0);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        r0 = rise_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        expect_char("after reset", 8'h3C, 1'b0, 1'b0, 1'b0);
        check("after reset count", rise_cnt - r0, 1);

        // Divisor 0 disables start detection entirely.
        div = 16'd0;
        b0  = busy_cnt;
        r0  = rise_cnt;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
        repeat (32) @(negedge clk);
        check("div0 busy", busy_cnt - b0, 0);
        check("div0 no char", rise_cnt - r0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
